gamepad_overlay_renderer: RTL and testbench
===========================================

GAMEPAD_OVERLAY_RENDERER -- requirements
Module: gamepad_overlay_renderer

Interface
REQ-001 SHALL have parameter NUM_PADS, default 2, number of gamepads drawn (1..2).
REQ-002 SHALL have parameter SCALE_SHIFT, default 2, glyph scale; cell size CELL_W = 8<<SCALE_SHIFT pixels.
REQ-003 SHALL have parameter GAP, default 8, horizontal pixels between cells; PITCH = CELL_W+GAP.
REQ-004 SHALL have parameters X0/Y0/ROW_PITCH, defaults 16/64/64, which set the layout origin and the vertical pad spacing.
REQ-005 SHALL have parameter HOLD_FRAMES, default 15, release-highlight duration in frames (0..255).
REQ-006 SHALL have parameter TICK_Y, default 480, the pix_y line carrying the frame tick.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 pix_x, pix_y  input  10 each  current pixel from the sync generator.
REQ-010 display_on  input  1  visible-area flag.
REQ-011 hsync_in, vsync_in  input  1 each  sync from the generator.
REQ-012 buttons  input  12*NUM_PADS  pressed=1; bit p*12+k; k order b,y,select,start,up,down,left,right,a,x,l,r.
REQ-013 pad_present  input  NUM_PADS  1 = pad connected.
REQ-014 rgb  output  6  {R[1:0],G[1:0],B[1:0]}, registered.
REQ-015 hsync_out, vsync_out  output  1 each  sync delayed to align with rgb.

Function
REQ-016 SHALL place cell (p,k) at x in [X0+k*PITCH, X0+k*PITCH+CELL_W) and y in [Y0+p*ROW_PITCH, Y0+p*ROW_PITCH+CELL_W); pixels outside every cell are background.
REQ-017 SHALL look up glyph bit row=(pix_y-cell_y)>>SCALE_SHIFT, col=(pix_x-cell_x)>>SCALE_SHIFT, bit index 7-col, from an internal 8x8 ROM per button k.
REQ-018 Glyph ROM row 7 SHALL be 8'hFF for every k (underline bar); rows 0-6 carry the button symbol.
REQ-019 SHALL generate a frame tick for exactly one cycle when pix_x==0 and pix_y==TICK_Y.
REQ-020 SHALL sample buttons and pad_present only on the frame tick; every state change SHALL occur on that tick only.
REQ-021 SHALL hold, per button, a state IDLE/PRESSED/DECAY plus an 8-bit counter.
REQ-022 At the tick: pressed -> PRESSED, from any state (this also applies when the button is pressed during DECAY).
REQ-023 At the tick: PRESSED and released -> DECAY with counter=HOLD_FRAMES-1; if HOLD_FRAMES==0, -> IDLE directly.
REQ-024 At the tick: DECAY and released -> IDLE if counter==0, else decrement the counter; DECAY SHALL therefore last exactly HOLD_FRAMES frames.
REQ-025 At the tick, if the pad is absent, SHALL force all 12 of its buttons to IDLE and ignore their button bits.
REQ-026 Glyph-on pixel colour SHALL be: PRESSED 6'b001100, DECAY 6'b111100, IDLE 6'b111111; absent pad 6'b010101.
REQ-027 Glyph-off and background pixels SHALL be 6'b000000; display_on==0 SHALL give 6'b000000.
REQ-028 SHALL pipeline in 2 stages: stage 1 cell decode and offset; stage 2 ROM lookup and colour.
REQ-029 rgb, hsync_out and vsync_out SHALL appear exactly 2 clk cycles after the corresponding pix_x/pix_y/display_on/hsync_in/vsync_in.
REQ-030 Subtractions SHALL use 10-bit unsigned arithmetic, evaluated only inside the cell range, so no wrap is visible.
REQ-031 pix_x beyond the last cell (k>11) SHALL render as background.

Reset
REQ-032 While rst_n=0, rgb SHALL be 0, hsync_out and vsync_out SHALL be 1, all states SHALL be IDLE, all counters 0 and the pipeline empty.
REQ-033 Reset asserted mid-frame SHALL take effect immediately; after release, the first tick samples inputs normally.
REQ-034 The frame tick SHALL NOT fire during reset.

Verification
REQ-035 Defaults, pad 0 present, no buttons; drive (20,93) with display_on=1 -> rgb=6'b111111 two cycles later; drive (50,93) -> 0 (gap).
REQ-036 Set buttons[0]=1 before a tick -> (20,93) gives 6'b001100 for that frame; release before the next tick -> 6'b111100 for 15 frames, 6'b111111 on the 16th.
REQ-037 HOLD_FRAMES=0 build; press then release -> green then directly white on the next frame, never yellow.
REQ-038 Press during DECAY frame 5 -> green at the next tick; release afterwards -> full 15-frame DECAY again.
REQ-039 pad_present[1]=0 with buttons[12]=1 -> pad 1 cell 0 at (20,157) gives 6'b010101, never green; display_on=0 -> 0.
REQ-040 Toggle hsync_in and vsync_in and assert rst_n=0 mid-frame -> sync outputs lag by exactly 2 cycles; during reset rgb=0 and sync outputs=1.

Source files
------------

// File: rtl/gamepad_overlay_renderer.sv
// Draws a grid of 8x8 scaled button glyphs per gamepad over a pixel stream, coloured by
// per-button press/decay state updated once per frame; 2-cycle pixel pipeline with aligned syncs.
module gamepad_overlay_renderer #(
  parameter int unsigned NUM_PADS    = 2,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned GAP         = 8,
  parameter int unsigned X0          = 16,
  parameter int unsigned Y0          = 64,
  parameter int unsigned ROW_PITCH   = 64,
  parameter int unsigned HOLD_FRAMES = 15,
  parameter int unsigned TICK_Y      = 480
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    display_on,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic [12*NUM_PADS-1:0]  buttons,
  input  logic [NUM_PADS-1:0]     pad_present,
  output logic [5:0]              rgb,
  output logic                    hsync_out,
  output logic                    vsync_out
);

  localparam int unsigned CELL_W  = 32'd8 << SCALE_SHIFT;
  localparam int unsigned PITCH   = CELL_W + GAP;
  localparam int unsigned NBTN    = 12;
  localparam int unsigned NB      = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_DECAY} btn_state_e;

  btn_state_e  st_q  [NB];
  logic [7:0]  cnt_q [NB];
  logic [1:0]  pres_q;
  logic [1:0]  pres_d;
  logic [23:0] btn_d;
  logic        frame_tick;

  logic        x_hit, y_hit;
  logic [3:0]  k_c;
  logic        pad_c;
  logic [9:0]  off_x, off_y;

  logic        s1_vld_q, s1_vld_d;
  logic [3:0]  s1_btn_q;
  logic        s1_pad_q;
  logic [2:0]  s1_row_q, s1_row_d;
  logic [2:0]  s1_col_q, s1_col_d;
  logic        s1_hs_q, s1_vs_q;

  logic [4:0]  s1_idx;
  logic [7:0]  glyph_row;
  logic        glyph_bit;
  logic [5:0]  rgb_d;

  assign frame_tick = (pix_x == 10'd0) && (pix_y == 10'(TICK_Y));
  assign pres_d     = 2'(pad_present);
  assign btn_d      = 24'(buttons);

  // Glyph rows 0-6 packed MSB-first; row 7 is the shared underline bar.
  function automatic logic [7:0] glyph(input logic [3:0] k, input logic [2:0] r);
    logic [55:0] g;
    logic [5:0]  sh;
    case (k)
      4'd0:    g = 56'h60607C6666667C;
      4'd1:    g = 56'h66663C18181818;
      4'd2:    g = 56'h007E4242427E00;
      4'd3:    g = 56'h0060787E786000;
      4'd4:    g = 56'h183C7E18181800;
      4'd5:    g = 56'h001818187E3C18;
      4'd6:    g = 56'h0010307E301000;
      4'd7:    g = 56'h00080C7E0C0800;
      4'd8:    g = 56'h3C66667E666666;
      4'd9:    g = 56'h66663C183C6666;
      4'd10:   g = 56'h6060606060607E;
      4'd11:   g = 56'h7C66667C786C66;
      default: g = '0;
    endcase
    sh = {3'(3'd6 - r), 3'b000};
    if (r == 3'd7) glyph = 8'hFF;
    else           glyph = 8'(g >> sh);
  endfunction

  // Stage 1 decode: which cell (if any) the pixel falls in, and the offset inside it.
  always_comb begin
    x_hit = 1'b0;
    k_c   = '0;
    off_x = '0;
    y_hit = 1'b0;
    pad_c = 1'b0;
    off_y = '0;
    for (int unsigned k = 0; k < NBTN; k++) begin
      if ((32'(pix_x) >= X0 + k*PITCH) && (32'(pix_x) < X0 + k*PITCH + CELL_W)) begin
        x_hit = 1'b1;
        k_c   = 4'(k);
        off_x = pix_x - 10'(X0 + k*PITCH);
      end
    end
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      if ((32'(pix_y) >= Y0 + p*ROW_PITCH) && (32'(pix_y) < Y0 + p*ROW_PITCH + CELL_W)) begin
        y_hit = 1'b1;
        pad_c = 1'(p);
        off_y = pix_y - 10'(Y0 + p*ROW_PITCH);
      end
    end
  end

  assign s1_vld_d = display_on && x_hit && y_hit;
  assign s1_row_d = 3'(off_y >> SCALE_SHIFT);
  assign s1_col_d = 3'(off_x >> SCALE_SHIFT);

  // Stage 2: glyph lookup and state colour.
  assign s1_idx    = 5'(s1_pad_q) * 5'd12 + 5'(s1_btn_q);
  assign glyph_row = glyph(s1_btn_q, s1_row_q);
  assign glyph_bit = glyph_row[3'd7 - s1_col_q];

  always_comb begin
    rgb_d = 6'b000000;
    if (s1_vld_q && glyph_bit) begin
      if (!pres_q[s1_pad_q]) begin
        rgb_d = 6'b010101;
      end else begin
        case (st_q[s1_idx])
          ST_PRESSED: rgb_d = 6'b001100;
          ST_DECAY:   rgb_d = 6'b111100;
          default:    rgb_d = 6'b111111;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_btn_q  <= '0;
      s1_pad_q  <= 1'b0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      s1_hs_q   <= 1'b1;
      s1_vs_q   <= 1'b1;
      rgb       <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_btn_q  <= k_c;
      s1_pad_q  <= pad_c;
      s1_row_q  <= s1_row_d;
      s1_col_q  <= s1_col_d;
      s1_hs_q   <= hsync_in;
      s1_vs_q   <= vsync_in;
      rgb       <= rgb_d;
      hsync_out <= s1_hs_q;
      vsync_out <= s1_vs_q;
    end
  end

  // Per-button state machine; advances only on the frame tick. Unbuilt pads read as absent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_q <= '0;
      for (int unsigned i = 0; i < NB; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
    end else if (frame_tick) begin
      pres_q <= pres_d;
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned k = 0; k < NBTN; k++) begin
          if (!pres_d[p]) begin
            st_q[p*NBTN+k]  <= ST_IDLE;
            cnt_q[p*NBTN+k] <= '0;
          end else if (btn_d[p*NBTN+k]) begin
            st_q[p*NBTN+k]  <= ST_PRESSED;
            cnt_q[p*NBTN+k] <= '0;
          end else begin
            case (st_q[p*NBTN+k])
              ST_PRESSED: begin
                if (HOLD_FRAMES == 0) begin
                  st_q[p*NBTN+k] <= ST_IDLE;
                end else begin
                  st_q[p*NBTN+k]  <= ST_DECAY;
                  cnt_q[p*NBTN+k] <= 8'(HOLD_FRAMES - 1);
                end
              end
              ST_DECAY: begin
                if (cnt_q[p*NBTN+k] == 8'd0) st_q[p*NBTN+k] <= ST_IDLE;
                else cnt_q[p*NBTN+k] <= cnt_q[p*NBTN+k] - 8'd1;
              end
              default: st_q[p*NBTN+k] <= ST_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gamepad_overlay_renderer.sv
// Bench for gamepad_overlay_renderer: fixed vectors, hand-built press/decay sequences and
// random frames against an arithmetic layout/state model, for HOLD_FRAMES=15 and 0 builds.
module tb_gamepad_overlay_renderer;

  localparam int X0 = 16, Y0 = 64, ROWP = 64, CELL = 32, PITCH = 40, TICKY = 480;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        display_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [23:0] buttons = '0;
  logic [1:0]  pad_present = '0;
  logic [5:0]  rgb_a, rgb_b;
  logic        hs_a, vs_a, hs_b, vs_b;

  always #5 clk = ~clk;

  gamepad_overlay_renderer dut_a (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .buttons(buttons), .pad_present(pad_present),
    .rgb(rgb_a), .hsync_out(hs_a), .vsync_out(vs_a));

  gamepad_overlay_renderer #(.HOLD_FRAMES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .buttons(buttons), .pad_present(pad_present),
    .rgb(rgb_b), .hsync_out(hs_b), .vsync_out(vs_b));

  typedef struct { logic [5:0] ra; logic [5:0] rb; logic hs; logic vs; int x; int y; } exp_t;
  typedef struct { int x; int y; bit de; int exp; } vec_t;

  exp_t hist[$];
  int   n_vec = 0, n_mis = 0;

  // Model: mode 0 idle, 1 pressed, 2 decay; left = visible decay frames remaining.
  int   mode [2][24];
  int   left [2][24];
  int   holdv [2] = '{15, 0};
  bit   pres_m [2];
  logic [55:0] gly [12] = '{56'h60607C6666667C, 56'h66663C18181818, 56'h007E4242427E00,
                            56'h0060787E786000, 56'h183C7E18181800, 56'h001818187E3C18,
                            56'h0010307E301000, 56'h00080C7E0C0800, 56'h3C66667E666666,
                            56'h66663C183C6666, 56'h6060606060607E, 56'h7C66667C786C66};

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 24; i++) begin mode[d][i] = 0; left[d][i] = 0; end
    pres_m[0] = 1'b0; pres_m[1] = 1'b0;
  endtask

  task automatic model_tick();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 24; i++) begin
        if (!pad_present[i/12]) begin
          mode[d][i] = 0;
        end else if (buttons[i]) begin
          mode[d][i] = 1;
        end else if (mode[d][i] == 1) begin
          mode[d][i] = (holdv[d] == 0) ? 0 : 2;
          left[d][i] = holdv[d];
        end else if (mode[d][i] == 2) begin
          left[d][i] = left[d][i] - 1;
          if (left[d][i] == 0) mode[d][i] = 0;
        end
      end
    pres_m[0] = pad_present[0]; pres_m[1] = pad_present[1];
  endtask

  function automatic logic [5:0] model_rgb(int d, int x, int y, bit de);
    int dx, dy, k, p, ox, oy, row, col, line;
    if (!de || x < X0 || y < Y0) return 6'h00;
    dx = x - X0; dy = y - Y0;
    k = dx / PITCH; p = dy / ROWP; ox = dx % PITCH; oy = dy % ROWP;
    if (k > 11 || p > 1 || ox >= CELL || oy >= CELL) return 6'h00;
    row = oy / (CELL / 8); col = ox / (CELL / 8);
    line = (row == 7) ? 255 : int'((gly[k] >> (8 * (6 - row))) & 56'hFF);
    if (((line >> (7 - col)) & 1) == 0) return 6'h00;
    if (!pres_m[p]) return 6'h15;
    case (mode[d][p*12+k])
      1:       return 6'h0C;
      2:       return 6'h3C;
      default: return 6'h3F;
    endcase
  endfunction

  task automatic check(input exp_t e, input string tag);
    n_vec++;
    if (rgb_a !== e.ra || rgb_b !== e.rb || hs_a !== e.hs || vs_a !== e.vs ||
        hs_b !== e.hs || vs_b !== e.vs) begin
      n_mis++;
      $display("FAIL %s px(%0d,%0d) rgb_a=%h want %h rgb_b=%h want %h hs=%b%b want %b vs=%b%b want %b",
               tag, e.x, e.y, rgb_a, e.ra, rgb_b, e.rb, hs_a, hs_b, e.hs, vs_a, vs_b, e.vs);
    end
  endtask

  // One pixel per clock; checks the output for the pixel driven two cycles earlier.
  task automatic cycle(input int x, input int y, input bit de, input bit hs, input bit vs,
                       input bit r, input int ea, input int eb);
    exp_t e, rst_e;
    rst_e = '{ra: 6'h00, rb: 6'h00, hs: 1'b1, vs: 1'b1, x: -1, y: -1};
    @(posedge clk); #1;
    if (hist.size() == 2) begin
      e = hist.pop_front();
      check(e, "pipe");
    end
    if (!r && rst_n) begin
      rst_n = 1'b0;
      #1;
      check(rst_e, "rst_now");
      hist.delete();
      hist.push_back(rst_e);
      model_reset();
    end else if (r && !rst_n) begin
      rst_n = 1'b1;
    end
    pix_x = 10'(x); pix_y = 10'(y); display_on = de; hsync_in = hs; vsync_in = vs;
    if (rst_n && x == 0 && y == TICKY) model_tick();
    if (!rst_n) begin
      e = rst_e;
    end else begin
      e.ra = (ea >= 0) ? 6'(ea) : model_rgb(0, x, y, de);
      e.rb = (eb >= 0) ? 6'(eb) : model_rgb(1, x, y, de);
      e.hs = hs; e.vs = vs;
    end
    e.x = x; e.y = y;
    hist.push_back(e);
  endtask

  task automatic tick(input logic [23:0] b, input logic [1:0] p);
    buttons = b; pad_present = p;
    cycle(0, TICKY, 1'b0, 1'($urandom), 1'($urandom), 1'b1, -1, -1);
  endtask

  task automatic probe(input int ea, input int eb);
    cycle(20, 93, 1'b1, 1'($urandom), 1'($urandom), 1'b1, ea, eb);
    cycle(20, 70, 1'b1, 1'($urandom), 1'($urandom), 1'b1, -1, -1);
  endtask

  // After a press: one release tick, then HOLD_FRAMES yellow frames before white.
  task automatic release_seq();
    for (int i = 1; i <= 16; i++) begin
      tick(24'h0, 2'b11);
      probe((i <= 15) ? 6'h3C : 6'h3F, 6'h3F);
    end
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{x: 20,  y: 93,  de: 1'b1, exp: 6'h3F};
    tbl[1]  = '{x: 50,  y: 93,  de: 1'b1, exp: 6'h00};
    tbl[2]  = '{x: 20,  y: 157, de: 1'b1, exp: 6'h15};
    tbl[3]  = '{x: 20,  y: 157, de: 1'b0, exp: 6'h00};
    tbl[4]  = '{x: 15,  y: 93,  de: 1'b1, exp: 6'h00};
    tbl[5]  = '{x: 495, y: 93,  de: 1'b1, exp: 6'h00};
    tbl[6]  = '{x: 456, y: 93,  de: 1'b1, exp: 6'h3F};
    tbl[7]  = '{x: 500, y: 93,  de: 1'b1, exp: 6'h00};
    tbl[8]  = '{x: 20,  y: 95,  de: 1'b1, exp: 6'h3F};
    tbl[9]  = '{x: 20,  y: 96,  de: 1'b1, exp: 6'h00};
    tbl[10] = '{x: 20,  y: 64,  de: 1'b1, exp: 6'h3F};
    tbl[11] = '{x: 16,  y: 64,  de: 1'b1, exp: 6'h00};

    model_reset();
    for (int i = 0; i < 4; i++) cycle(20, 93, 1'b1, 1'(i), 1'(i + 1), 1'b0, -1, -1);

    // Pad 1 absent with its first button held: must show absent colour, not green.
    tick(24'h001000, 2'b01);
    for (int i = 0; i < 12; i++)
      cycle(tbl[i].x, tbl[i].y, tbl[i].de, 1'($urandom), 1'($urandom), 1'b1, tbl[i].exp, tbl[i].exp);

    tick(24'h000001, 2'b11);
    probe(6'h0C, 6'h0C);
    release_seq();

    // Re-press during decay, then a full decay again.
    tick(24'h000001, 2'b11);
    probe(6'h0C, 6'h0C);
    for (int i = 1; i <= 5; i++) begin
      tick(24'h0, 2'b11);
      probe(6'h3C, 6'h3F);
    end
    tick(24'h000001, 2'b11);
    probe(6'h0C, 6'h0C);
    release_seq();

    for (int f = 0; f < 40; f++) begin
      tick(24'($urandom & $urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
      for (int j = 0; j < 30; j++) begin
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
          x = X0 + int'($urandom_range(0, 11)) * PITCH + int'($urandom_range(0, 35));
          y = Y0 + int'($urandom_range(0, 1)) * ROWP + int'($urandom_range(0, 33));
        end else begin
          x = int'($urandom_range(0, 519));
          y = int'($urandom_range(56, 200));
        end
        cycle(x, y, ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
              !(f == 20 && j >= 10 && j < 13), -1, -1);
      end
    end

    cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
    cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
    cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
